// File: rtl/xip_pkg.sv
// Shared definitions for the XIP line buffer: AXI response codes, controller
// states and the line-offset helper.
package xip_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } lb_state_t;

  // Bit position of the tag LSB: word-index bits plus the two byte-lane bits.
  function automatic int lb_ofs(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/xip_lb_fill_ctrl.sv
// Master-side AR/R sequencer that fetches one aligned line, one read at a time.
// With XIP_LB_CWF_EN defined the fill starts at the requested word and wraps.
module xip_lb_fill_ctrl
  import xip_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  localparam int OFS       = lb_ofs(LINE_WORDS),
  localparam int IDXW      = OFS - 2,
  localparam int TAGW      = ADDR_W - OFS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic [TAGW-1:0]   i_tag,
  input  logic [IDXW-1:0]   i_first,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  output logic              o_beat,
  output logic [IDXW-1:0]   o_beat_idx,
  output logic              o_done,
  output logic              o_line_ok,
  output logic              o_resp_err
);

  logic            r_busy;
  logic            r_arvalid;
  logic [TAGW-1:0] r_tag;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_cnt;
  logic            r_err;
  logic            r_flush;
  logic            w_beat;
  logic            w_beat_err;
  logic            w_err_any;
  logic            w_last;

  // R beats are only taken once the matching AR has been accepted.
  assign w_beat     = r_busy && !r_arvalid && m_rvalid_i;
  assign w_beat_err = (m_rresp_i != RESP_OKAY);
  assign w_err_any  = r_err || w_beat_err;
  assign w_last     = (r_cnt == {IDXW{1'b1}});

  assign m_araddr_o  = {r_tag, r_idx, 2'b00};
  assign m_arvalid_o = r_arvalid;
  assign m_rready_o  = r_busy;
  assign o_beat      = w_beat;
  assign o_beat_idx  = r_idx;
  assign o_done      = w_beat && w_last;
  assign o_line_ok   = !w_err_any && !r_flush && !i_flush;
`ifdef XIP_LB_CWF_EN
  assign o_resp_err  = w_beat_err;
`else
  assign o_resp_err  = w_err_any;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy    <= 1'b0;
      r_arvalid <= 1'b0;
      r_tag     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_flush   <= 1'b0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_arvalid <= 1'b1;
      r_tag     <= i_tag;
      r_idx     <= i_first;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_flush   <= 1'b0;
    end else if (r_busy) begin
      if (i_flush) r_flush <= 1'b1;
      if (r_arvalid && m_arready_i) r_arvalid <= 1'b0;
      if (w_beat) begin
        r_err <= w_err_any;
        if (w_last) begin
          r_busy <= 1'b0;
        end else begin
          // Index wraps naturally because LINE_WORDS is a power of two.
          r_cnt     <= r_cnt + 1'b1;
          r_idx     <= r_idx + 1'b1;
          r_arvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xip_line_buffer.sv
// Single-line read buffer in front of xip_engine: serves hits locally, fills a
// whole aligned line on a miss. Optional critical-word-first via XIP_LB_CWF_EN.
module xip_line_buffer
  import xip_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_araddr_i,
  input  logic              s_arvalid_i,
  output logic              s_arready_o,
  output logic [31:0]       s_rdata_o,
  output logic [1:0]        s_rresp_o,
  output logic              s_rvalid_o,
  input  logic              s_rready_i,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [31:0]       m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic              flush_i,
  output logic              hit_o,
  output logic              miss_o
);

  localparam int OFS  = lb_ofs(LINE_WORDS);
  localparam int IDXW = OFS - 2;
  localparam int TAGW = ADDR_W - OFS;

  lb_state_t       r_state;
  logic [TAGW-1:0] r_tag;
  logic [TAGW-1:0] r_req_tag;
  logic [IDXW-1:0] r_req_idx;
  logic            r_line_valid;
  logic            r_arready;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            r_hit;
  logic            r_miss;
`ifdef XIP_LB_CWF_EN
  logic            r_resp_acc;
`endif
  logic [31:0]     r_buf [LINE_WORDS];

  logic [TAGW-1:0] w_req_tag;
  logic [IDXW-1:0] w_req_idx;
  logic [IDXW-1:0] w_first;
  logic            w_accept;
  logic            w_lookup_hit;
  logic            w_fill_start;
  logic            w_beat;
  logic [IDXW-1:0] w_beat_idx;
  logic            w_done;
  logic            w_line_ok;
  logic            w_resp_err;

  assign w_req_tag    = s_araddr_i[ADDR_W-1:OFS];
  assign w_req_idx    = s_araddr_i[OFS-1:2];
  assign w_accept     = (r_state == IDLE) && r_arready && s_arvalid_i;
  // A same-cycle flush must turn the lookup into a miss.
  assign w_lookup_hit = r_line_valid && !flush_i && (r_tag == w_req_tag);
  assign w_fill_start = w_accept && !w_lookup_hit;
`ifdef XIP_LB_CWF_EN
  assign w_first      = w_req_idx;
`else
  assign w_first      = '0;
`endif

  assign s_arready_o = r_arready;
  assign s_rvalid_o  = r_rvalid;
  assign s_rdata_o   = r_rdata;
  assign s_rresp_o   = r_rresp;
  assign hit_o       = r_hit;
  assign miss_o      = r_miss;

  xip_lb_fill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_fill (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_fill_start),
    .i_tag       (w_req_tag),
    .i_first     (w_first),
    .i_flush     (flush_i),
    .m_araddr_o  (m_araddr_o),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_rresp_i   (m_rresp_i),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .o_beat      (w_beat),
    .o_beat_idx  (w_beat_idx),
    .o_done      (w_done),
    .o_line_ok   (w_line_ok),
    .o_resp_err  (w_resp_err)
  );

  always_ff @(posedge clk) begin
    if (w_beat) r_buf[w_beat_idx] <= m_rdata_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_line_valid <= 1'b0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
`ifdef XIP_LB_CWF_EN
      r_resp_acc   <= 1'b0;
`endif
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (flush_i) r_line_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_arready <= 1'b1;
          if (w_accept) begin
            r_arready <= 1'b0;
            r_req_tag <= w_req_tag;
            r_req_idx <= w_req_idx;
            if (w_lookup_hit) begin
              r_hit    <= 1'b1;
              r_rvalid <= 1'b1;
              r_rdata  <= r_buf[w_req_idx];
              r_rresp  <= RESP_OKAY;
              r_state  <= RESP;
            end else begin
              r_miss       <= 1'b1;
              r_line_valid <= 1'b0;
              r_state      <= FILL;
`ifdef XIP_LB_CWF_EN
              r_resp_acc   <= 1'b0;
`endif
            end
          end
        end
        FILL: begin
`ifdef XIP_LB_CWF_EN
          // Requested word goes out as soon as it lands; the fill keeps running.
          if (w_beat && (w_beat_idx == r_req_idx)) begin
            r_rvalid <= 1'b1;
            r_rdata  <= m_rdata_i;
            r_rresp  <= w_resp_err ? RESP_SLVERR : RESP_OKAY;
          end
          if (r_rvalid && s_rready_i) begin
            r_rvalid   <= 1'b0;
            r_resp_acc <= 1'b1;
          end
          if (w_done) begin
            r_line_valid <= w_line_ok;
            r_tag        <= r_req_tag;
            if (r_resp_acc || (r_rvalid && s_rready_i)) begin
              r_arready <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state   <= RESP;
            end
          end
`else
          if (w_done) begin
            r_line_valid <= w_line_ok;
            r_tag        <= r_req_tag;
            r_rvalid     <= 1'b1;
            // The requested word may be the beat arriving this very cycle.
            r_rdata      <= (w_beat_idx == r_req_idx) ? m_rdata_i : r_buf[r_req_idx];
            r_rresp      <= w_resp_err ? RESP_SLVERR : RESP_OKAY;
            r_state      <= RESP;
          end
`endif
        end
        RESP: begin
          if (s_rready_i) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xip_line_buffer.sv
// Directed plus randomized bench for xip_line_buffer with a behavioural line
// model and an AXI-Lite slave that returns addr^32'hA5A5_0000.
module tb_xip_line_buffer;

  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] s_araddr_i;
  logic          s_arvalid_i;
  logic          s_arready_o;
  logic [31:0]   s_rdata_o;
  logic [1:0]    s_rresp_o;
  logic          s_rvalid_o;
  logic          s_rready_i;
  logic [AW-1:0] m_araddr_o;
  logic          m_arvalid_o;
  logic          m_arready_i;
  logic [31:0]   m_rdata_i;
  logic [1:0]    m_rresp_i;
  logic          m_rvalid_i;
  logic          m_rready_o;
  logic          flush_i;
  logic          hit_o;
  logic          miss_o;

  xip_line_buffer #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_araddr_i  (s_araddr_i),
    .s_arvalid_i (s_arvalid_i),
    .s_arready_o (s_arready_o),
    .s_rdata_o   (s_rdata_o),
    .s_rresp_o   (s_rresp_o),
    .s_rvalid_o  (s_rvalid_o),
    .s_rready_i  (s_rready_i),
    .m_araddr_o  (m_araddr_o),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_rdata_i   (m_rdata_i),
    .m_rresp_i   (m_rresp_i),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .flush_i     (flush_i),
    .hit_o       (hit_o),
    .miss_o      (miss_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit          err_en   = 1'b0;
  logic [31:0] err_addr = '0;
  bit          aborted  = 1'b0;
  int          ar_fixed = -1;
  logic [31:0] mar_q[$];

  bit          ref_valid = 1'b0;
  logic [27:0] ref_tag   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flash-side slave: random AR stall, random R latency, optional SLVERR word.
  initial begin : slave
    m_arready_i = 1'b0;
    m_rvalid_i  = 1'b0;
    m_rdata_i   = '0;
    m_rresp_i   = 2'b00;
    forever begin
      tick();
      if (m_arvalid_o && resetn) begin
        logic [31:0] a;
        int d;
        a = m_araddr_o;
        d = (ar_fixed >= 0) ? ar_fixed : int'($urandom_range(3, 0));
        for (int i = 0; i < d; i++) begin
          tick();
          if (!aborted) begin
            chk("ar_hold", m_arvalid_o, 1);
            chk("araddr_stable", m_araddr_o, a);
          end
        end
        m_arready_i = 1'b1;
        mar_q.push_back(a);
        tick();
        m_arready_i = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
        m_rvalid_i = 1'b1;
        m_rdata_i  = a ^ 32'hA5A5_0000;
        m_rresp_i  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
        tick();
        m_rvalid_i = 1'b0;
      end
    end
  end

  task automatic wait_arready();
    int n = 0;
    while (!s_arready_o && n < 300) begin
      tick();
      n++;
    end
    chk("arready_wait", s_arready_o, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly, input bit fl_same, input bit fl_fill);
    logic [31:0] exp_addrs[$];
    logic [31:0] wa;
    logic [31:0] fa;
    logic [1:0]  exp_resp;
    bit          exp_hit;
    bit          line_err;
    int          first;
    int          n;
    wait_arready();
    exp_hit = ref_valid && !fl_same && (ref_tag == addr[31:4]);
    wa = {addr[31:2], 2'b00};
    first = 0;
`ifdef XIP_LB_CWF_EN
    first = int'(addr[3:2]);
`endif
    line_err = 1'b0;
    for (int k = 0; k < LW; k++) begin
      fa = {addr[31:4], 4'h0} + 32'(((first + k) % LW) * 4);
      exp_addrs.push_back(fa);
      if (err_en && fa == err_addr) line_err = 1'b1;
    end
`ifdef XIP_LB_CWF_EN
    exp_resp = (!exp_hit && err_en && wa == err_addr) ? 2'b10 : 2'b00;
`else
    exp_resp = (!exp_hit && line_err) ? 2'b10 : 2'b00;
`endif
    mar_q.delete();
    s_araddr_i  = addr;
    s_arvalid_i = 1'b1;
    flush_i     = fl_same;
    tick();
    s_arvalid_i = 1'b0;
    flush_i     = 1'b0;
    chk("hit_o", hit_o, exp_hit);
    chk("miss_o", miss_o, !exp_hit);
    if (exp_hit) chk("hit_latency", s_rvalid_o, 1);
    if (fl_fill && !exp_hit) begin
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    n = 0;
    while (!s_rvalid_o && n < 300) begin
      tick();
      n++;
    end
    chk("rvalid_wait", s_rvalid_o, 1);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("rvalid_hold", s_rvalid_o, 1);
      chk("rdata_stable", s_rdata_o, wa ^ 32'hA5A5_0000);
      chk("rresp_stable", s_rresp_o, exp_resp);
    end
    chk("rdata", s_rdata_o, wa ^ 32'hA5A5_0000);
    chk("rresp", s_rresp_o, exp_resp);
    s_rready_i = 1'b1;
    tick();
    s_rready_i = 1'b0;
    wait_arready();
    if (exp_hit) begin
      chk("hit_no_fetch", mar_q.size(), 0);
    end else begin
      chk("fetch_count", mar_q.size(), LW);
      if (mar_q.size() == LW)
        for (int k = 0; k < LW; k++) chk("fetch_addr", mar_q[k], exp_addrs[k]);
      ref_valid = !line_err && !fl_fill;
      ref_tag   = addr[31:4];
    end
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ref_valid = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    resetn      = 1'b0;
    s_araddr_i  = '0;
    s_arvalid_i = 1'b0;
    s_rready_i  = 1'b0;
    flush_i     = 1'b0;
    repeat (3) tick();
    chk("rst_slave_outs", {s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o, hit_o, miss_o}, 0);
    chk("rst_master_outs", {m_araddr_o, m_arvalid_o, m_rready_o}, 0);
    resetn = 1'b1;
    repeat (2) tick();
    chk("arready_after_rst", s_arready_o, 1);

    ar_fixed = 0;
    do_read(32'h0000_0008, 0, 0, 0);
    do_read(32'h0000_000C, 0, 0, 0);
    do_read(32'h0000_0010, 0, 0, 0);
    do_read(32'h0000_0000, 1, 0, 0);
    do_read(32'h0000_0004, 0, 0, 0);
    flush_pulse();
    do_read(32'h0000_0004, 0, 0, 0);
    do_read(32'h0000_0008, 0, 1, 0);
    do_read(32'h0000_0020, 0, 0, 1);
    do_read(32'h0000_0024, 0, 0, 0);

    err_en   = 1'b1;
    err_addr = 32'h0000_0008;
    do_read(32'h0000_0004, 0, 0, 0);
    do_read(32'h0000_0004, 0, 0, 0);
    do_read(32'h0000_0008, 2, 0, 0);
    err_en = 1'b0;
    do_read(32'h0000_0004, 0, 0, 0);
    do_read(32'h0000_0000, 0, 0, 0);

    ar_fixed = 3;
    do_read(32'h0000_0040, 5, 0, 0);
    do_read(32'h0000_0044, 5, 0, 0);
    ar_fixed = -1;

    wait_arready();
    s_araddr_i  = 32'h0000_0100;
    s_arvalid_i = 1'b1;
    tick();
    s_arvalid_i = 1'b0;
    repeat (3) tick();
    aborted = 1'b1;
    resetn  = 1'b0;
    #1;
    chk("midfill_rst_slave_outs", {s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o, hit_o, miss_o}, 0);
    chk("midfill_rst_master_outs", {m_araddr_o, m_arvalid_o, m_rready_o}, 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (30) tick();
    mar_q.delete();
    aborted   = 1'b0;
    ref_valid = 1'b0;
    do_read(32'h0000_0100, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(15, 0) * 4);
      do_read(ra, int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
